// File: rtl/lza_pkg.sv
// Shared constants and helpers for the leading-zero anticipator pipeline.
// WIDTH limits cover fp16 through fp64 mantissas with headroom.
package lza_pkg;

    localparam int LZA_WIDTH_MIN = 4;
    localparam int LZA_WIDTH_MAX = 128;

    function automatic int lza_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/lzc_tree.sv
// Combinational leading-zero counter built as a binary halving tree.
// The vector is zero-padded on the LSB side up to a power of two.
module lzc_tree
    import lza_pkg::*;
#(
    parameter int WIDTH = 53,
    parameter int CNT_W = lza_cnt_w(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             all_zero_o
);

    localparam int LG = $clog2(WIDTH);
    localparam int P  = 1 << LG;

    logic [P-1:0] vec_p;

    if (P > WIDTH) begin : g_pad
        assign vec_p = {vec_i, {(P-WIDTH){1'b0}}};
    end else begin : g_nopad
        assign vec_p = vec_i;
    end

    // Heap-numbered nodes: root 1, children 2n (MSB half) and 2n+1, leaves P..2P-1.
    logic [2*P-1:1]         v;
    logic [2*P-1:1][LG-1:0] c;

    for (genvar j = 0; j < P; j++) begin : g_leaf
        assign v[P+j] = vec_p[P-1-j];
        assign c[P+j] = '0;
    end

    for (genvar n = 1; n < P; n++) begin : g_node
        localparam int HALF = 1 << (LG - $clog2(n + 1));
        assign v[n] = v[2*n] | v[2*n+1];
        assign c[n] = v[2*n] ? c[2*n] : LG'(HALF) + c[2*n+1];
    end

    assign all_zero_o = ~v[1];
    assign cnt_o      = all_zero_o ? CNT_W'(WIDTH) : CNT_W'(c[1]);

endmodule

// File: rtl/lza_pipe.sv
// Two-stage leading-zero anticipator with valid/ready flow control, tag sideband
// and synchronous flush: S1 registers the indicator vector, S2 its leading-zero count.
module lza_pipe
    import lza_pkg::*;
#(
    parameter int WIDTH = 53,
    parameter int CNT_W = lza_cnt_w(WIDTH),
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] zero_cnt,
    output logic             all_zero,
    output logic [TAG_W-1:0] out_tag
);

    logic [WIDTH-1:2] t;
    logic [WIDTH-2:0] g, z;
    logic [WIDTH-1:0] f;

    assign t = in_a[WIDTH-1:2] ^ in_b[WIDTH-1:2];
    assign g = in_a[WIDTH-2:0] & in_b[WIDTH-2:0];
    assign z = ~in_a[WIDTH-2:0] & ~in_b[WIDTH-2:0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_ind
        if (i == WIDTH - 1) begin : g_msb
            assign f[i] = ~t[i] & t[i-1];
        end else if (i == 0) begin : g_lsb
            assign f[i] = 1'b0;
        end else begin : g_mid
            assign f[i] = ( t[i+1] & ((g[i] & ~z[i-1]) | (z[i] & ~g[i-1])))
                        | (~t[i+1] & ((z[i] & ~z[i-1]) | (g[i] & ~g[i-1])));
        end
    end

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_f_q, s1_f_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             az_q, az_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             s1_adv, s2_adv;
    logic [CNT_W-1:0] lzc_cnt;
    logic             lzc_az;

    lzc_tree #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lzc (
        .vec_i      (s1_f_q),
        .cnt_o      (lzc_cnt),
        .all_zero_o (lzc_az)
    );

    // Data registers load only on a real transfer so idle X operands never enter.
    always_comb begin
        s2_adv      = ~out_valid_q | out_ready;
        s1_adv      = ~s1_valid_q | s2_adv;
        s1_valid_d  = flush ? 1'b0 : (s1_adv ? in_valid : s1_valid_q);
        s1_f_d      = (s1_adv & in_valid) ? f : s1_f_q;
        s1_tag_d    = (s1_adv & in_valid) ? in_tag : s1_tag_q;
        out_valid_d = flush ? 1'b0 : (s2_adv ? s1_valid_q : out_valid_q);
        cnt_d       = (s2_adv & s1_valid_q) ? lzc_cnt : cnt_q;
        az_d        = (s2_adv & s1_valid_q) ? lzc_az : az_q;
        tag_d       = (s2_adv & s1_valid_q) ? s1_tag_q : tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_f_q      <= '0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            az_q        <= 1'b0;
            tag_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_f_q      <= s1_f_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            az_q        <= az_d;
            tag_q       <= tag_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = out_valid_q;
    assign zero_cnt  = cnt_q;
    assign all_zero  = az_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_lza_pipe.sv
// Directed and random checks of lza_pipe at WIDTH 53, 24 and 128 against a bitwise reference.
module tb_lza_pipe;

    localparam int W  = 53;
    localparam int CW = 6;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          az;
        logic [3:0]    tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, all_zero;
    logic [W-1:0]  in_a, in_b;
    logic [3:0]    in_tag, out_tag;
    logic [CW-1:0] zero_cnt;

    logic          rv;
    logic [23:0]   ra24, rb24;
    logic [127:0]  ra128, rb128;
    logic          r24_rdy, r24_ov, r24_az, r128_rdy, r128_ov, r128_az;
    logic [4:0]    r24_cnt;
    logic [7:0]    r128_cnt;
    logic [3:0]    r24_tag, r128_tag;

    int total = 0;
    int bad   = 0;
    int n_out = 0;

    exp_t  sb[$];
    int    q24[$];
    int    q128[$];
    exp_t  me;
    int    mc;
    logic  held_v = 1'b0;
    exp_t  held;

    always #5 clk = ~clk;

    lza_pipe #(.WIDTH(W), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .zero_cnt(zero_cnt), .all_zero(all_zero), .out_tag(out_tag)
    );

    lza_pipe #(.WIDTH(24)) u24 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(rv), .in_ready(r24_rdy),
        .in_a(ra24), .in_b(rb24), .in_tag(4'd0),
        .out_valid(r24_ov), .out_ready(1'b1),
        .zero_cnt(r24_cnt), .all_zero(r24_az), .out_tag(r24_tag)
    );

    lza_pipe #(.WIDTH(128)) u128 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(rv), .in_ready(r128_rdy),
        .in_a(ra128), .in_b(rb128), .in_tag(4'd0),
        .out_valid(r128_ov), .out_ready(1'b1),
        .zero_cnt(r128_cnt), .all_zero(r128_az), .out_tag(r128_tag)
    );

    task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", nm, obs, exp);
        end
    endtask

    // Reference: indicator straight from its bit equations, then a linear scan.
    function automatic int ref_cnt(input logic [127:0] a, input logic [127:0] b, input int w);
        logic [127:0] t, g, z, f;
        t = a ^ b; g = a & b; z = ~a & ~b; f = '0;
        f[w-1] = ~t[w-1] & t[w-2];
        for (int i = 1; i <= w - 2; i++)
            f[i] = (t[i+1] & ((g[i] & ~z[i-1]) | (z[i] & ~g[i-1])))
                 | (~t[i+1] & ((z[i] & ~z[i-1]) | (g[i] & ~g[i-1])));
        for (int i = w - 1; i >= 0; i--)
            if (f[i]) return w - 1 - i;
        return w;
    endfunction

    function automatic exp_t model53(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] tg);
        exp_t e;
        int   c;
        c = ref_cnt({75'd0, a}, {75'd0, b}, W);
        e.cnt = CW'(c);
        e.az  = (c == W);
        e.tag = tg;
        return e;
    endfunction

    // Scoreboard monitor: pushes on accept, pops on output, all sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete(); q24.delete(); q128.delete();
            held_v = 1'b0;
        end else begin
            check("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
            if (held_v) begin
                check("hold_vld", out_valid, 1);
                check("hold_dat", {zero_cnt, all_zero, out_tag}, held);
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    me = sb.pop_front();
                    check("result", {zero_cnt, all_zero, out_tag}, me);
                    n_out++;
                end
            end
            held_v = out_valid && !out_ready && !flush;
            held   = {zero_cnt, all_zero, out_tag};
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(model53(in_a, in_b, in_tag));

            if (r24_ov) begin
                check("r24_nonempty", q24.size() > 0, 1);
                if (q24.size() > 0) begin
                    mc = q24.pop_front();
                    check("r24_res", {r24_cnt, r24_az}, {mc[4:0], mc == 24});
                end
            end
            if (r128_ov) begin
                check("r128_nonempty", q128.size() > 0, 1);
                if (q128.size() > 0) begin
                    mc = q128.pop_front();
                    check("r128_res", {r128_cnt, r128_az}, {mc[7:0], mc == 128});
                end
            end
            if (rv) begin
                check("r24_rdy", r24_rdy, 1);
                check("r128_rdy", r128_rdy, 1);
                q24.push_back(ref_cnt({104'd0, ra24}, {104'd0, rb24}, 24));
                q128.push_back(ref_cnt(ra128, rb128, 128));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k, n0, r;
        logic acc, orp, fresh;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_tag = '0;
        rv = 1'b0; ra24 = '0; rb24 = '0; ra128 = '0; rb128 = '0;

        // Reset state
        repeat (2) step();
        check("rst_ovld", out_valid, 0);
        check("rst_cnt", zero_cnt, 0);
        check("rst_az", all_zero, 0);
        check("rst_tag", out_tag, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rdy", in_ready, 1);
        step();

        // a=0, b=1: latency 2, count 51
        in_a = '0; in_b = 53'd1; in_tag = 4'd5; in_valid = 1'b1;
        @(negedge clk);
        check("t1_rdy", in_ready, 1);
        step();
        in_valid = 1'b0; in_a = 'x; in_b = 'x;
        @(negedge clk);
        check("t1_lat1", out_valid, 0);
        @(negedge clk);
        check("t1_lat2", out_valid, 1);
        check("t1_cnt", zero_cnt, 51);
        check("t1_az", all_zero, 0);
        check("t1_tag", out_tag, 5);
        step();

        // a=2^52, b=0 -> 1 ; a=b=0 -> 53 with all_zero
        in_a = '0; in_a[W-1] = 1'b1; in_b = '0; in_tag = 4'd1; in_valid = 1'b1;
        step();
        in_a = '0; in_b = '0; in_tag = 4'd2;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("t2_cnt1", zero_cnt, 1);
        check("t2_tag1", out_tag, 1);
        step();
        @(negedge clk);
        check("t2_cnt53", zero_cnt, 53);
        check("t2_az", all_zero, 1);
        check("t2_tag2", out_tag, 2);
        step();

        // 8 back-to-back ops, out_ready toggling 1010..
        n0 = n_out; k = 0; orp = 1'b1; fresh = 1'b1;
        for (int cyc = 0; cyc < 100 && k < 8; cyc++) begin
            if (fresh) begin
                in_a = {$urandom, $urandom} >> $urandom_range(11, 50);
                in_b = {$urandom, $urandom} >> $urandom_range(11, 50);
                in_tag = 4'(k);
            end
            in_valid = 1'b1; out_ready = orp;
            @(negedge clk);
            acc = in_ready;
            step();
            orp = !orp;
            fresh = acc;
            if (acc) k++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 40 && n_out < n0 + 8; i++) begin
            out_ready = orp;
            step();
            orp = !orp;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_count", n_out - n0, 8);
        check("t3_sb_empty", sb.size(), 0);
        step();

        // Full pipeline, then a one-cycle flush
        out_ready = 1'b0;
        in_a = 53'h3; in_b = 53'h10; in_tag = 4'd9; in_valid = 1'b1;
        step();
        in_tag = 4'd10;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_full_rdy", in_ready, 0);
        check("t4_full_vld", out_valid, 1);
        step();
        flush = 1'b1; in_valid = 1'b1; in_tag = 4'd11;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("t4_ovld", out_valid, 0);
        check("t4_rdy", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            check("t4_no_old", out_valid, 0);
        end
        step();

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        in_a = 53'h5; in_b = 53'h0; in_tag = 4'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        check("t5_pre_vld", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_vld", out_valid, 0);
        check("t5_rst_cnt", zero_cnt, 0);
        check("t5_rst_az", all_zero, 0);
        check("t5_rst_tag", out_tag, 0);
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        in_a = '0; in_b = 53'd1; in_tag = 4'd6; in_valid = 1'b1;
        @(negedge clk);
        check("t5_rdy", in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_lat1", out_valid, 0);
        @(negedge clk);
        check("t5_lat2", out_valid, 1);
        check("t5_tag", out_tag, 6);
        check("t5_cnt", zero_cnt, 51);
        step();

        // Random operands on the 24- and 128-bit builds
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 7);
            ra128 = {$urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 127);
            ra24  = 24'($urandom) >> $urandom_range(0, 23);
            if (r == 0) begin
                ra128 = '0; rb128 = '0; ra24 = '0; rb24 = '0;
            end else if (r == 1) begin
                rb128 = ~ra128; rb24 = ~ra24;
            end else begin
                rb128 = {$urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 127);
                rb24  = 24'($urandom) >> $urandom_range(0, 23);
            end
            rv = 1'b1;
            step();
        end
        rv = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("r24_drained", q24.size(), 0);
        check("r128_drained", q128.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
